// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one BRAM read port between N_REQ engines plus a host override.
// Optional stall counter enabled by defining ARB_STALL_COUNT_EN.

module bram_rr_arbiter_lane #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  grant,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] addr_sel
);
  assign addr_sel = grant ? addr : '0;
endmodule

module bram_rr_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 64,
  parameter int BRAM_LATENCY = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]       resp_data,
  input  logic                        host_en,
  input  logic [ADDR_WIDTH-1:0]       host_addr,
  input  logic                        host_valid,
  output logic [ADDR_WIDTH-1:0]       bram_r_addr,
  output logic                        bram_r_valid,
  input  logic [DATA_WIDTH-1:0]       bram_r_data,
  output logic [$clog2(N_REQ)-1:0]    grant_idx,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        stall_cycles
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0]                  ptr_q;
  logic [IDX_W-1:0]                  win_idx;
  logic                              win_found;
  logic                              eng_grant;
  logic [N_REQ-1:0]                  grant_oh;
  logic [N_REQ-1:0][ADDR_WIDTH-1:0]  addr_sel;
  logic [ADDR_WIDTH-1:0]             addr_or;
  logic [BRAM_LATENCY:1]             vld_pipe;
  logic [BRAM_LATENCY:1][IDX_W-1:0]  idx_pipe;

  // Rotating priority scan: first valid requester at or after the pointer.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  // Host override and reset both suppress engine grants in the same cycle.
  assign eng_grant = win_found & ~host_en & ~rst;
  assign grant_oh  = eng_grant ? (N_REQ'(1) << win_idx) : '0;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    bram_rr_arbiter_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .grant    (grant_oh[i]),
      .addr     (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .addr_sel (addr_sel[i])
    );
  end

  always_comb begin
    addr_or = '0;
    for (int i = 0; i < N_REQ; i++) addr_or = addr_or | addr_sel[i];
  end

  always_comb begin
    req_ready    = grant_oh;
    grant_idx    = eng_grant ? win_idx : '0;
    bram_r_addr  = '0;
    bram_r_valid = 1'b0;
    if (!rst) begin
      bram_r_addr  = host_en ? host_addr : addr_or;
      bram_r_valid = host_en ? host_valid : eng_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (eng_grant) begin
      ptr_q <= (int'(win_idx) == N_REQ-1) ? '0 : win_idx + 1'b1;
    end
  end

  // Response tag pipeline aligned to the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[1] <= eng_grant;
      idx_pipe[1] <= win_idx;
      for (int s = 2; s <= BRAM_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
    end
  end

  assign resp_valid = (vld_pipe[BRAM_LATENCY] && !rst) ?
                      (N_REQ'(1) << idx_pipe[BRAM_LATENCY]) : '0;
  assign resp_data  = bram_r_data;
  assign busy       = ~rst & (|vld_pipe);

`ifdef ARB_STALL_COUNT_EN
  logic [CNT_WIDTH-1:0] stall_q;
  logic                 stall_evt;

  // Grants are forced low under host_en, so this also covers host-blocked requests.
  assign stall_evt = |(req_valid & ~grant_oh);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall_evt && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = rst ? '0 : stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Randomized and directed bench for bram_rr_arbiter against a queue-based reference model.
module tb_bram_rr_arbiter;
  localparam int N = 4;
  localparam int A = 9;
  localparam int D = 64;
  localparam int L = 2;
  localparam int C = 32;
  localparam int OW = N + 1 + A + 2 + N + 1 + C;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*A-1:0] req_addr;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [D-1:0]   resp_data;
  logic           host_en;
  logic [A-1:0]   host_addr;
  logic           host_valid;
  logic [A-1:0]   bram_r_addr;
  logic           bram_r_valid;
  logic [D-1:0]   bram_r_data;
  logic [1:0]     grant_idx;
  logic           busy;
  logic [C-1:0]   stall_cycles;

  always #5 clk = ~clk;

  bram_rr_arbiter #(.N_REQ(N), .ADDR_WIDTH(A), .DATA_WIDTH(D), .BRAM_LATENCY(L), .CNT_WIDTH(C)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .host_en(host_en), .host_addr(host_addr),
    .host_valid(host_valid), .bram_r_addr(bram_r_addr), .bram_r_valid(bram_r_valid),
    .bram_r_data(bram_r_data), .grant_idx(grant_idx), .busy(busy), .stall_cycles(stall_cycles)
  );

  // BRAM model: content is a fixed hash of the address, delivered L cycles after the read.
  function automatic logic [D-1:0] memval(input logic [A-1:0] a);
    return 64'hA5A5_0000_0000_0000 ^ ({55'd0, a} * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  logic [A-1:0] a_pipe [1:L];
  always @(posedge clk) begin
    a_pipe[1] <= bram_r_addr;
    for (int s = 2; s <= L; s++) a_pipe[s] <= a_pipe[s-1];
  end
  assign bram_r_data = memval(a_pipe[L]);

  typedef struct { int due; int idx; logic [A-1:0] addr; } rd_t;
  rd_t          q[$];
  int           ptr_m, cyc, checks, failures;
  logic [C-1:0] stall_m;
  logic         e_dchk;
  logic [D-1:0] e_data;
  logic [OW-1:0] exp_v;
  wire  [OW-1:0] obs = {req_ready, bram_r_valid, bram_r_addr, grant_idx, resp_valid, busy, stall_cycles};

  // Drive one cycle and compute the expected observation from the arbitration rules.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*A-1:0] a,
                      input logic he, input logic [A-1:0] ha, input logic hv);
    logic [N-1:0] e_ready, e_resp;
    logic [A-1:0] e_addr;
    logic         e_bv, e_busy, found;
    logic [1:0]   e_gidx;
    logic [C-1:0] e_stall;
    rd_t          kept[$];
    @(posedge clk); #1;
    rst = r; req_valid = v; req_addr = a; host_en = he; host_addr = ha; host_valid = hv;
    #1; cyc++;
    e_ready = '0; e_resp = '0; e_addr = '0; e_bv = 0; e_busy = 0; e_gidx = '0;
    e_dchk = 0; e_data = '0; found = 0;
`ifdef ARB_STALL_COUNT_EN
    e_stall = r ? '0 : stall_m;
`else
    e_stall = '0;
`endif
    if (r) begin
      q.delete(); ptr_m = 0; stall_m = '0;
    end else begin
      foreach (q[k]) begin
        if (q[k].due == cyc) begin
          if (q[k].idx >= 0) e_resp[q[k].idx] = 1'b1;
          e_dchk = 1; e_data = memval(q[k].addr);
        end
        if (q[k].idx >= 0 && q[k].due >= cyc) e_busy = 1;
      end
      if (he) begin
        e_addr = ha; e_bv = hv;
        if (hv) q.push_back('{cyc + L, -1, ha});
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (ptr_m + k) % N;
          if (!found && v[j]) begin
            found = 1; e_ready[j] = 1'b1; e_addr = a[j*A +: A]; e_bv = 1; e_gidx = 2'(j);
            q.push_back('{cyc + L, j, a[j*A +: A]});
            ptr_m = (j + 1) % N;
          end
        end
      end
      if ((he ? |v : |(v & ~e_ready)) && stall_m != '1) stall_m = stall_m + 1;
      foreach (q[k]) if (q[k].due > cyc) kept.push_back(q[k]);
      q = kept;
    end
    exp_v = {e_ready, e_bv, e_addr, e_gidx, e_resp, e_busy, e_stall};
  endtask

  function automatic logic [N*A-1:0] rand_addrs();
    logic [N*A-1:0] x;
    for (int i = 0; i < N; i++) x[i*A +: A] = A'($urandom);
    return x;
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(1, 4'b1111, rand_addrs(), 0, '0, 0);
      checks++;
      if (obs !== '0 || obs !== exp_v) begin
        failures++; $display("FAIL reset c%0d obs=%h exp=%h", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_single();
    logic [N*A-1:0] a;
    a = rand_addrs(); a[2*A +: A] = 9'h010;
    step(1, '0, '0, 0, '0, 0);
    step(0, 4'b0100, a, 0, '0, 0);
    checks++;
    if (req_ready !== 4'b0100 || bram_r_addr !== 9'h010) begin
      failures++; $display("FAIL single_grant ready=%b addr=%h exp 0100/010", req_ready, bram_r_addr);
    end
    for (int k = 0; k < L + 1; k++) begin
      if (k > 0) step(0, '0, '0, 0, '0, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL single c%0d obs=%h exp=%h", cyc, obs, exp_v); end
      if (e_dchk) begin
        checks++;
        if (resp_data !== e_data) begin failures++; $display("FAIL single_data got=%h exp=%h", resp_data, e_data); end
      end
    end
  endtask

  task automatic test_all_four();
    step(1, '0, '0, 0, '0, 0);
    for (int k = 0; k < 8 + L; k++) begin
      step(0, (k < 8) ? 4'b1111 : 4'b0000, rand_addrs(), 0, '0, 0);
      if (k < 8) begin
        checks++;
        if (grant_idx !== 2'(k % 4)) begin failures++; $display("FAIL rr_seq k=%0d got=%0d exp=%0d", k, grant_idx, k % 4); end
      end
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL all_four c%0d obs=%h exp=%h", cyc, obs, exp_v); end
      if (e_dchk) begin
        checks++;
        if (resp_data !== e_data) begin failures++; $display("FAIL all_four_data got=%h exp=%h", resp_data, e_data); end
      end
    end
  endtask

  task automatic test_pointer_wrap();
    logic [N-1:0] pat [5];
    logic [1:0]   gexp [3];
    pat = '{4'b0010, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
    gexp = '{2'd1, 2'd3, 2'd1};
    step(1, '0, '0, 0, '0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, pat[k], rand_addrs(), 0, '0, 0);
      if (k < 3) begin
        checks++;
        if (grant_idx !== gexp[k]) begin failures++; $display("FAIL wrap_grant k=%0d got=%0d exp=%0d", k, grant_idx, gexp[k]); end
      end
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL wrap c%0d obs=%h exp=%h", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_host();
    step(1, '0, '0, 0, '0, 0);
    step(0, 4'b0001, rand_addrs(), 0, '0, 0);
    step(0, 4'b1111, rand_addrs(), 1, 9'h1FF, 1);
    checks++;
    if (req_ready !== '0 || bram_r_addr !== 9'h1FF || bram_r_valid !== 1'b1) begin
      failures++; $display("FAIL host_override ready=%b addr=%h v=%b", req_ready, bram_r_addr, bram_r_valid);
    end
    for (int k = 0; k < L + 1; k++) begin
      if (k > 0) step(0, 4'b1111, rand_addrs(), 1, 9'h0AA, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL host c%0d obs=%h exp=%h", cyc, obs, exp_v); end
      if (e_dchk) begin
        checks++;
        if (resp_data !== e_data) begin failures++; $display("FAIL host_data got=%h exp=%h", resp_data, e_data); end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, '0, '0, 0, '0, 0);
    step(0, 4'b1000, rand_addrs(), 0, '0, 0);
    step(1, 4'b1111, rand_addrs(), 0, '0, 0);
    for (int k = 0; k < L + 1; k++) begin
      step(0, (k == L) ? 4'b0110 : 4'b0000, rand_addrs(), 0, '0, 0);
      checks++;
      if (resp_valid !== '0 || busy !== 1'b0) begin
        failures++; $display("FAIL rst_drop resp=%b busy=%b exp 0000/0", resp_valid, busy);
      end
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL rst_mid c%0d obs=%h exp=%h", cyc, obs, exp_v); end
    end
    checks++;
    if (grant_idx !== 2'd1) begin failures++; $display("FAIL rst_lowest got=%0d exp=1", grant_idx); end
  endtask

  task automatic test_stall();
    step(1, '0, '0, 0, '0, 0);
    for (int k = 0; k < 4; k++) step(0, 4'b0011, rand_addrs(), 0, '0, 0);
    step(0, '0, '0, 0, '0, 0);
    checks++;
`ifdef ARB_STALL_COUNT_EN
    if (stall_cycles !== 32'd4) begin failures++; $display("FAIL stall_count got=%0d exp=4", stall_cycles); end
`else
    if (stall_cycles !== 32'd0) begin failures++; $display("FAIL stall_count got=%0d exp=0", stall_cycles); end
`endif
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL stall c%0d obs=%h exp=%h", cyc, obs, exp_v); end
  endtask

  task automatic test_random();
    step(1, '0, '0, 0, '0, 0);
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 64) == 0, N'($urandom), rand_addrs(), ($urandom % 8) == 0,
           A'($urandom), 1'($urandom));
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL random c%0d obs=%h exp=%h", cyc, obs, exp_v); end
      if (e_dchk) begin
        checks++;
        if (resp_data !== e_data) begin failures++; $display("FAIL random_data c%0d got=%h exp=%h", cyc, resp_data, e_data); end
      end
    end
  endtask

  initial begin
    rst = 1; req_valid = '0; req_addr = '0; host_en = 0; host_addr = '0; host_valid = 0;
    ptr_m = 0; cyc = 0; checks = 0; failures = 0; stall_m = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_all_four();
    test_pointer_wrap();
    test_host();
    test_reset_mid();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Shares the single read port of the instruction/data BRAM between N regex engines (multi-engine coprocessor build), plus a host (AXI command) override path.
- Round-robin arbitration on valid/ready request channels; returns read data after a fixed BRAM latency, tagged to the granted requester.
- Sits between the AXI top-level controller / engine array and the bram instance, replacing the direct coprocessor-to-BRAM hookup.

Parameters:
- N_REQ, 4, number of requesting engines (2..16).
- ADDR_WIDTH, 9, BRAM read address width.
- DATA_WIDTH, 64, BRAM read data width.
- BRAM_LATENCY, 1, cycles from r_valid/r_addr to r_data valid (1..4).
- CNT_WIDTH, 32, width of the optional stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester read request
- req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH+:ADDR_WIDTH]
- req_ready  out  N_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- resp_valid  out  N_REQ  one-hot, 1-cycle pulse: read data for requester i
- resp_data  out  DATA_WIDTH  read data, broadcast to all requesters
- host_en  in  1  host override: 1 = requests blocked, port owned by host
- host_addr  in  ADDR_WIDTH  host read address
- host_valid  in  1  host read strobe
- bram_r_addr  out  ADDR_WIDTH  to BRAM read address
- bram_r_valid  out  1  to BRAM read enable
- bram_r_data  in  DATA_WIDTH  from BRAM read data
- grant_idx  out  $clog2(N_REQ)  index of current winner (0 when none)
- busy  out  1  any response in flight
- stall_cycles  out  CNT_WIDTH  see Optional Feature

Behaviour:
- Reset values: req_ready=0, resp_valid=0, bram_r_valid=0, bram_r_addr=0, grant_idx=0, busy=0, priority pointer=0, in-flight pipeline cleared, stall_cycles=0.
- Arbitration is combinational within the cycle: winner = first i with req_valid[i]=1, scanning from pointer upward and wrapping modulo N_REQ.
- On a win with host_en=0: req_ready[winner]=1 (only that bit), bram_r_addr=req_addr[winner], bram_r_valid=1, grant_idx=winner, pointer <= (winner+1) mod N_REQ at clock edge.
- No valid requester: req_ready=0, bram_r_valid=0, bram_r_addr=0, pointer unchanged.
- req_ready must not depend on a request being held over cycles; a requester may drop req_valid any cycle it is not granted.
- One grant per cycle max; full throughput = 1 read/cycle.
- Response pipeline: BRAM_LATENCY-deep shift register of {valid, idx}. Exactly BRAM_LATENCY cycles after a grant at cycle t, resp_valid[idx]=1 and resp_data=bram_r_data at t+BRAM_LATENCY. No response backpressure; requesters must accept.
- resp_data = bram_r_data every cycle (unqualified when resp_valid=0).
- busy = OR of pipeline valid bits.
- host_en=1: req_ready=0, bram_r_addr=host_addr, bram_r_valid=host_valid, no pipeline entry inserted, pointer frozen; host reads its data from resp_data after BRAM_LATENCY (host's own timing). In-flight engine responses still complete normally.
- host_en toggles take effect the same cycle; no drain wait.
- rst mid-operation: in-flight responses dropped (no resp_valid afterwards), pointer=0.
- Request index beyond N_REQ impossible by construction; pointer wrap from N_REQ-1 to 0.

Optional Feature:
- Macro ARB_STALL_COUNT_EN.
- Defined: stall_cycles increments each cycle where host_en=1 and any req_valid, or host_en=0 and any req_valid[i]=1 with req_ready[i]=0. Saturates at all-ones. Cleared by rst.
- Not defined: stall_cycles tied to 0, no counter logic.

Test Plan:
- BRAM_LATENCY=1, only req_valid[2]=1, addr 0x010 at cycle t -> req_ready=4'b0100 at t, bram_r_addr=0x010, resp_valid=4'b0100 at t+1 with resp_data=mem[0x010].
- All four requesters valid for 8 cycles after reset -> grant_idx sequence 0,1,2,3,0,1,2,3, one resp_valid pulse per cycle delayed by 1.
- Pointer at 2 (after granting 1), req_valid=4'b1010 -> grant 3 then 1; BRAM_LATENCY=3 -> responses 3 cycles after each grant.
- Grant to 0 at t, host_en=1 at t+1 with host_addr=0x1FF, req_valid=4'b1111 -> req_ready=0, bram_r_addr=0x1FF, resp_valid[0] still pulses at t+1.
- BRAM_LATENCY=2, grant at t, rst at t+1 -> no resp_valid at t+2, busy=0, next grant goes to lowest valid index.
- ARB_STALL_COUNT_EN defined, req_valid=4'b0011 held for 4 cycles -> stall_cycles=4; undefined -> stall_cycles=0.
